// File: rtl/load_store_unit.sv
// Load/store unit: turns one datapath load/store into a single handshaked bus
// transaction, stalls the core until it completes, and steers/extends the data.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        misalign_fault,
    output logic        bus_error,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on a cycle with bus_valid & bus_ready; while
    // bus_valid is high without ready, bus_we/addr/wdata/wstrb stay stable. A
    // response is one cycle of bus_rsp_valid, accepted with ready or any later cycle.

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    lane_q;
    logic [2:0]    f3_q;

    logic          legal;
    logic [3:0]    store_strb;
    logic [31:0]   store_data;
    logic [7:0]    load_byte;
    logic [15:0]   load_half;
    logic [31:0]   load_ext;
    logic          rsp_done;
    logic          timeout_hit;

    assign bus_valid = (state == REQ);
    assign stall     = mem_req && (state != DONE);
    assign dbg_state = state;

    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000:  legal = 1'b1;
            3'b100:  legal = !mem_we;
            3'b001:  legal = !addr[0];
            3'b101:  legal = !mem_we && !addr[0];
            3'b010:  legal = (addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        store_strb = 4'b1111;
        store_data = wdata;
        case (funct3[1:0])
            2'b00: begin
                store_strb = 4'b0001 << addr[1:0];
                store_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                store_strb = 4'b0011 << addr[1:0];
                store_data = {2{wdata[15:0]}};
            end
            default: begin
                store_strb = 4'b1111;
                store_data = wdata;
            end
        endcase
    end

    // Lane selection uses the address latched at request time, not the live input.
    always_comb begin
        load_byte = bus_rdata[7:0];
        case (lane_q)
            2'd0:    load_byte = bus_rdata[7:0];
            2'd1:    load_byte = bus_rdata[15:8];
            2'd2:    load_byte = bus_rdata[23:16];
            default: load_byte = bus_rdata[31:24];
        endcase
        load_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_ext  = bus_rdata;
        case (f3_q)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_ext = {24'h0, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b101:  load_ext = {16'h0, load_half};
            default: load_ext = bus_rdata;
        endcase
    end

    assign rsp_done    = ((state == REQ) && bus_ready && bus_rsp_valid) ||
                         ((state == RESP) && bus_rsp_valid);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((state == REQ) || (state == RESP)) &&
                         (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            lane_q         <= 2'b00;
            f3_q           <= 3'b000;
            bus_we         <= 1'b0;
            bus_addr       <= 32'h0;
            bus_wdata      <= 32'h0;
            bus_wstrb      <= 4'h0;
            ReadData       <= 32'h0;
            misalign_fault <= 1'b0;
            bus_error      <= 1'b0;
        end else begin
            misalign_fault <= 1'b0;
            bus_error      <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        if (legal) begin
                            state     <= REQ;
                            cnt       <= '0;
                            bus_we    <= mem_we;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wdata <= store_data;
                            bus_wstrb <= mem_we ? store_strb : 4'b0000;
                            lane_q    <= addr[1:0];
                            f3_q      <= funct3;
                        end else begin
                            state          <= DONE;
                            misalign_fault <= 1'b1;
                            ReadData       <= 32'h0;
                        end
                    end
                end
                REQ, RESP: begin
                    // A response arriving on the last allowed cycle beats the timeout.
                    if (rsp_done) begin
                        state    <= DONE;
                        ReadData <= bus_we ? 32'h0 : load_ext;
                    end else if (timeout_hit) begin
                        state     <= DONE;
                        bus_error <= 1'b1;
                        ReadData  <= 32'h0;
                    end else begin
                        if ((state == REQ) && bus_ready) begin
                            state <= RESP;
                        end
                        if (TIMEOUT_CYCLES != 0) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed transactions against a size/lane model,
// checked every cycle by one compare process, plus literal pins and a reset case.
module tb_load_store_unit;

    localparam int TO = 8;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ReadData;
    logic        stall;
    logic        misalign_fault;
    logic        bus_error;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;
    logic [1:0]  dbg_state;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .ReadData(ReadData), .stall(stall),
        .misalign_fault(misalign_fault), .bus_error(bus_error), .bus_valid(bus_valid),
        .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata),
        .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic        legal;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        logic        berr;
        logic [7:0]  stalls;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    exp_t pin;

    int n_checks = 0;
    int n_pass = 0;
    int seen_stalls = 0;
    logic        saw_valid;
    logic [31:0] last_addr, last_wdata, last_rdata;
    logic [3:0]  last_strb;
    logic        last_fault, last_berr;
    int          last_stalls;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Model: access = `size` bytes starting at byte lane `lane` of the word.
    function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rd,
                                   input int rdy, input int rsp);
        exp_t e;
        int size, lane, tot;
        longint v;
        e = '0;
        lane = int'(a[1:0]);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e.legal = ((f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                   (!we && ((f3 == 3'd4) || (f3 == 3'd5)))) && ((lane % size) == 0);
        e.we = we;
        e.addr = a - 32'(lane);
        if (!e.legal) begin
            e.fault = 1'b1;
            e.stalls = 8'd1;
            return e;
        end
        tot = rdy + 1 + rsp;
        if (tot > TO) begin
            e.berr = 1'b1;
            e.stalls = 8'(1 + TO);
        end else begin
            e.stalls = 8'(1 + tot);
        end
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= lane && i < lane + size) e.strb[i] = 1'b1;
                e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
            end
        end else if (!e.berr) begin
            v = longint'({32'h0, rd} >> (8 * lane));
            if (size < 4) begin
                v = v % (longint'(1) << (8 * size));
                if (!f3[2] && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
            end
            e.rdata = 32'(v);
        end
        return e;
    endfunction

    // scoreboard / compare process
    always @(negedge clk) begin
        if (reset && mem_req && exp_q.size() > 0) begin
            cur = exp_q[0];
            if (bus_valid) begin
                check("bus_valid_legal", 32'(cur.legal), 32'd1);
                check("bus_addr", bus_addr, cur.addr);
                check("bus_we", 32'(bus_we), 32'(cur.we));
                check("bus_wstrb", 32'(bus_wstrb), 32'(cur.strb));
                if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
                saw_valid = 1'b1;
                last_addr = bus_addr;
                last_strb = bus_wstrb;
                last_wdata = bus_wdata;
            end
            if (stall) begin
                seen_stalls++;
                check("pulses_quiet", {30'h0, misalign_fault, bus_error}, 32'h0);
            end else begin
                check("stall_cycles", 32'(seen_stalls), 32'(cur.stalls));
                check("ReadData", ReadData, cur.rdata);
                check("misalign_fault", 32'(misalign_fault), 32'(cur.fault));
                check("bus_error", 32'(bus_error), 32'(cur.berr));
                check("done_no_valid", 32'(bus_valid), 32'h0);
                last_rdata = ReadData;
                last_fault = misalign_fault;
                last_berr = bus_error;
                last_stalls = seen_stalls;
                seen_stalls = 0;
                void'(exp_q.pop_front());
            end
        end else if (reset && !mem_req) begin
            check("idle_quiet", {30'h0, bus_valid, stall}, 32'h0);
        end
    end

    // driver tasks
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int rdy, input int rsp);
        int req_n, rsp_n;
        logic acc, done;
        exp_q.push_back(model(we, f3, a, wd, rd, rdy, rsp));
        req_n = 0; rsp_n = 0; acc = 1'b0; done = 1'b0;
        @(posedge clk); #1;
        saw_valid = 1'b0;
        mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd; bus_rdata = rd;
        for (int cyc = 0; cyc < 64; cyc++) begin
            #1;
            bus_ready = 1'b0;
            bus_rsp_valid = 1'b0;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            if (bus_valid) begin
                if (req_n == rdy) begin
                    bus_ready = 1'b1;
                    acc = 1'b1;
                    if (rsp == 0) bus_rsp_valid = 1'b1;
                end
                req_n++;
            end else if (acc) begin
                rsp_n++;
                if (rsp_n == rsp) bus_rsp_valid = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            $display("FAIL txn_budget: got stall=1 after 64 cycles expected stall=0");
            n_checks++;
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $fatal(1, "transaction hung");
        end
    endtask

    task automatic go_idle(input int n);
        @(posedge clk); #1;
        mem_req = 1'b0;
        bus_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        reset = 1'b0; mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'b000; addr = 32'h0;
        wdata = 32'h0; bus_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
        saw_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus_valid", 32'(bus_valid), 32'h0);
        check("rst_bus_we", 32'(bus_we), 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_bus_wstrb", 32'(bus_wstrb), 32'h0);
        check("rst_ReadData", ReadData, 32'h0);
        check("rst_pulses", {30'h0, misalign_fault, bus_error}, 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        check("rst_stall_idle", 32'(stall), 32'h0);
        mem_req = 1'b1; #1;
        check("rst_stall_req", 32'(stall), 32'h1);
        mem_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        // literal pins on the model itself
        pin = model(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF12, 0, 0);
        check("pin_lb", pin.rdata, 32'hFFFF_FF80);
        pin = model(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF12, 0, 0);
        check("pin_lbu", pin.rdata, 32'h0000_0080);
        pin = model(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 0, 0);
        check("pin_sh_strb", 32'(pin.strb), 32'hC);
        check("pin_sh_wdata", pin.wdata, 32'hABCD_ABCD);
        check("pin_sh_addr", pin.addr, 32'h200);

        // LW, ready+response on first request cycle
        do_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
        go_idle(1);
        check("lw_addr", last_addr, 32'h100);
        check("lw_strb", 32'(last_strb), 32'h0);
        check("lw_stalls", 32'(last_stalls), 32'd2);
        check("lw_rdata", last_rdata, 32'hDEAD_BEEF);

        do_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF12, 1, 1);
        go_idle(1);
        check("lb_rdata", last_rdata, 32'hFFFF_FF80);
        check("lb_stalls", 32'(last_stalls), 32'd4);

        // back-to-back group
        do_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF12, 0, 1);
        do_txn(1'b0, 3'b001, 32'h002, 32'h0, 32'h8001_7FFF, 0, 0);
        do_txn(1'b0, 3'b101, 32'h000, 32'h0, 32'h8001_7FFF, 2, 0);
        do_txn(1'b1, 3'b000, 32'h001, 32'h0000_0055, 32'h0, 0, 1);
        do_txn(1'b1, 3'b010, 32'h010, 32'hA5A5_1234, 32'h0, 1, 2);
        go_idle(1);

        do_txn(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 0, 0);
        go_idle(1);
        check("sh_addr", last_addr, 32'h200);
        check("sh_strb", 32'(last_strb), 32'hC);
        check("sh_wdata", last_wdata, 32'hABCD_ABCD);
        check("sh_rdata", last_rdata, 32'h0);

        do_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h1111_1111, 0, 0);
        go_idle(1);
        check("mis_no_bus", 32'(saw_valid), 32'h0);
        check("mis_fault", 32'(last_fault), 32'h1);
        check("mis_stalls", 32'(last_stalls), 32'd1);
        check("mis_rdata", last_rdata, 32'h0);

        // other illegal encodings
        do_txn(1'b0, 3'b001, 32'h001, 32'h0, 32'h0, 0, 0);
        do_txn(1'b1, 3'b100, 32'h000, 32'h0, 32'h0, 0, 0);
        do_txn(1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 0, 0);
        do_txn(1'b1, 3'b001, 32'h003, 32'h0, 32'h0, 0, 0);
        go_idle(1);

        // timeout and its boundary
        do_txn(1'b0, 3'b010, 32'h040, 32'h0, 32'h1234_5678, 99, 0);
        go_idle(1);
        check("to_berr", 32'(last_berr), 32'h1);
        check("to_stalls", 32'(last_stalls), 32'd9);
        check("to_rdata", last_rdata, 32'h0);
        do_txn(1'b0, 3'b010, 32'h044, 32'h0, 32'h0BAD_F00D, 3, 4);
        do_txn(1'b0, 3'b010, 32'h048, 32'h0, 32'h0BAD_F00D, 3, 6);
        do_txn(1'b0, 3'b000, 32'h04A, 32'h0, 32'h00FF_0000, 7, 0);
        go_idle(1);
        check("edge_rdata", last_rdata, 32'hFFFF_FFFF);

        // reset during RESP
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h300;
        @(posedge clk); #1;
        check("rt_req", 32'(bus_valid), 32'h1);
        bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        check("rt_resp_state", 32'(dbg_state), 32'd2);
        reset = 1'b0; #1;
        check("rt_valid_drop", 32'(bus_valid), 32'h0);
        check("rt_state_idle", 32'(dbg_state), 32'd0);
        check("rt_stall_held", 32'(stall), 32'h1);
        mem_req = 1'b0; #1;
        check("rt_stall_drop", 32'(stall), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        bus_rsp_valid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
        check("rt_late_state", 32'(dbg_state), 32'd0);
        check("rt_late_valid", 32'(bus_valid), 32'h0);
        check("rt_late_rdata", ReadData, 32'h0);
        check("rt_late_pulses", {30'h0, misalign_fault, bus_error}, 32'h0);
        repeat (2) @(posedge clk);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
